// File: rtl/encoder_pkg.sv
// Shared widths and constants for the registered 8-to-3 priority encoder.
package encoder_pkg;

    localparam int DATA_W = 8;
    localparam int CODE_W = $clog2(DATA_W);

    localparam logic [CODE_W-1:0] NO_REQ_CODE = 3'd0;

endpackage : encoder_pkg

// File: rtl/encoder_8x3_core.sv
// Combinational core: priority winner index, any-bit-set and two-or-more-bits-set detect.
module encoder_8x3_core
    import encoder_pkg::*;
#(
    parameter bit PRIORITY_HIGH = 1'b1
) (
    input  logic [DATA_W-1:0] data,
    output logic [CODE_W-1:0] w,
    output logic              any,
    output logic              many
);

    logic [3:0] any1_s;
    logic [3:0] many1_s;
    logic [1:0] any2_s;
    logic [1:0] many2_s;

    // Priority winner; the later assignment in the scan direction wins.
    always_comb begin
        w = NO_REQ_CODE;
        if (PRIORITY_HIGH) begin
            for (int i = 0; i < DATA_W; i++) begin
                if (data[i]) begin
                    w = CODE_W'(i);
                end else begin
                    w = w;
                end
            end
        end else begin
            for (int i = DATA_W - 1; i >= 0; i--) begin
                if (data[i]) begin
                    w = CODE_W'(i);
                end else begin
                    w = w;
                end
            end
        end
    end

    // Pairwise reduction: a merged pair has "many" if either half had many or both halves had any.
    always_comb begin
        any1_s  = 4'b0000;
        many1_s = 4'b0000;
        any2_s  = 2'b00;
        many2_s = 2'b00;
        for (int i = 0; i < 4; i++) begin
            any1_s[i]  = data[2*i] | data[2*i+1];
            many1_s[i] = data[2*i] & data[2*i+1];
        end
        for (int j = 0; j < 2; j++) begin
            any2_s[j]  = any1_s[2*j] | any1_s[2*j+1];
            many2_s[j] = many1_s[2*j] | many1_s[2*j+1] | (any1_s[2*j] & any1_s[2*j+1]);
        end
        any  = any2_s[0] | any2_s[1];
        many = many2_s[0] | many2_s[1] | (any2_s[0] & any2_s[1]);
    end

endmodule : encoder_8x3_core

// File: rtl/encoder_8x3.sv
// Registered 8-to-3 encoder: combinational core followed by an enable/reset output register stage.
module encoder_8x3
    import encoder_pkg::*;
#(
    parameter bit PRIORITY_HIGH = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [DATA_W-1:0] data,
    output logic [CODE_W-1:0] code,
    output logic              valid,
    output logic              multi
);

    logic [CODE_W-1:0] w_s;
    logic              any_s;
    logic              many_s;

    logic [CODE_W-1:0] code_d;
    logic [CODE_W-1:0] code_q;
    logic              valid_d;
    logic              valid_q;
    logic              multi_d;
    logic              multi_q;

    encoder_8x3_core #(
        .PRIORITY_HIGH (PRIORITY_HIGH)
    ) u_core (
        .data (data),
        .w    (w_s),
        .any  (any_s),
        .many (many_s)
    );

    // Next state: reset dominates enable, otherwise capture on enable or hold.
    always_comb begin
        code_d  = code_q;
        valid_d = valid_q;
        multi_d = multi_q;
        if (!rst_n) begin
            code_d  = NO_REQ_CODE;
            valid_d = 1'b0;
            multi_d = 1'b0;
        end else if (en) begin
            code_d  = w_s;
            valid_d = any_s;
            multi_d = many_s;
        end else begin
            code_d  = code_q;
            valid_d = valid_q;
            multi_d = multi_q;
        end
    end

    // Output register stage.
    always_ff @(posedge clk) begin
        code_q  <= code_d;
        valid_q <= valid_d;
        multi_q <= multi_d;
    end

    assign code  = code_q;
    assign valid = valid_q;
    assign multi = multi_q;

endmodule : encoder_8x3

// File: tb/tb_encoder_8x3.sv
// Directed self-checking bench for encoder_8x3 with high- and low-priority instances side by side.
module tb_encoder_8x3;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [7:0] data;

    logic [2:0] code_hi;
    logic       valid_hi;
    logic       multi_hi;
    logic [2:0] code_lo;
    logic       valid_lo;
    logic       multi_lo;

    int checks;
    int errors;

    encoder_8x3 #(.PRIORITY_HIGH(1'b1)) dut_hi (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .data  (data),
        .code  (code_hi),
        .valid (valid_hi),
        .multi (multi_hi)
    );

    encoder_8x3 #(.PRIORITY_HIGH(1'b0)) dut_lo (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .data  (data),
        .code  (code_lo),
        .valid (valid_lo),
        .multi (multi_lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [2:0] c_got, input logic v_got, input logic m_got,
                       input logic [2:0] c_exp, input logic v_exp, input logic m_exp);
        checks++;
        assert ({c_got, v_got, m_got} === {c_exp, v_exp, m_exp})
        else begin
            errors++;
            $error("FAIL %s: got code=%0d valid=%0b multi=%0b, expected code=%0d valid=%0b multi=%0b",
                   tag, c_got, v_got, m_got, c_exp, v_exp, m_exp);
        end
    endtask

    task automatic chk_both(input string tag,
                            input logic [2:0] c_hi, input logic [2:0] c_lo,
                            input logic v_exp, input logic m_exp);
        chk({tag, "_hi"}, code_hi, valid_hi, multi_hi, c_hi, v_exp, m_exp);
        chk({tag, "_lo"}, code_lo, valid_lo, multi_lo, c_lo, v_exp, m_exp);
    endtask

    initial begin
        checks = 0;
        errors = 0;

        // Reset state
        rst_n = 1'b0;
        en    = 1'b0;
        data  = 8'h00;
        tick();
        chk_both("reset", 3'd0, 3'd0, 1'b0, 1'b0);
        rst_n = 1'b1;

        // Walking one: same code for both priorities
        en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            data = 8'h01 << i;
            tick();
            chk_both($sformatf("walk%0d", i), 3'(i), 3'(i), 1'b1, 1'b0);
        end

        // Zero input
        data = 8'h00;
        tick();
        chk_both("zero", 3'd0, 3'd0, 1'b0, 1'b0);

        // Priority resolution on multi-bit inputs
        data = 8'h81;
        tick();
        chk_both("p81", 3'd7, 3'd0, 1'b1, 1'b1);
        data = 8'h0C;
        tick();
        chk_both("p0C", 3'd3, 3'd2, 1'b1, 1'b1);
        data = 8'hFE;
        tick();
        chk_both("pFE", 3'd7, 3'd1, 1'b1, 1'b1);
        data = 8'h50;
        tick();
        chk_both("p50", 3'd6, 3'd4, 1'b1, 1'b1);
        data = 8'h18;
        tick();
        chk_both("p18", 3'd4, 3'd3, 1'b1, 1'b1);

        // Enable hold
        data = 8'h20;
        tick();
        chk_both("load20", 3'd5, 3'd5, 1'b1, 1'b0);
        en   = 1'b0;
        data = 8'h02;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_both($sformatf("hold%0d", k), 3'd5, 3'd5, 1'b1, 1'b0);
        end
        en = 1'b1;
        tick();
        chk_both("resume", 3'd1, 3'd1, 1'b1, 1'b0);

        // Reset overrides enable, then first capture after release
        data  = 8'hFF;
        rst_n = 1'b0;
        tick();
        chk_both("midrst", 3'd0, 3'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick();
        chk_both("postrst", 3'd7, 3'd0, 1'b1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_encoder_8x3

// File: doc/encoder_8x3.md
# encoder_8x3

Registered 8-to-3 binary encoder with priority resolution and input-quality flags. It converts an 8-bit request/one-hot vector into a 3-bit index. It also reports whether any bit was set and whether more than one bit was set. It sits between a request/one-hot source and index-consuming logic, and provides a clean, clocked index with one cycle of latency.

## Interface
- `PRIORITY_HIGH`, default 1. 1 means the highest-numbered set bit wins; 0 means the lowest-numbered set bit wins.
- `clk` input 1: single clock. All state updates on the rising edge.
- `rst_n` input 1: reset. One clock; reset is synchronous and active-low.
- `en` input 1: capture enable. When high, the encoder samples `data` on the rising edge.
- `data` input 8: input vector. Bit i set means index i is requested.
- `code` output 3: encoded index of the winning bit, registered.
- `valid` output 1: registered. 1 when at least one bit of the captured `data` was set.
- `multi` output 1: registered. 1 when two or more bits of the captured `data` were set, meaning the input was not one-hot.

## Operation
- Combinational core computes three results from `data`:
  - winner index `w`, by priority per `PRIORITY_HIGH`;
  - `any = |data`;
  - `many`, which is set when the popcount of `data` is ≥ 2.
- One-hot input 2^i gives `code` = i (0..7) with `valid`=1 and `multi`=0, independent of `PRIORITY_HIGH`.
- Zero input gives `code`=0, `valid`=0, `multi`=0. `code`=0 with `valid`=0 is the defined "no request" encoding.
- Multi-bit input:
  - `code` is the priority winner, e.g. 8'b1000_0001 gives 7 when `PRIORITY_HIGH`=1 and 0 when `PRIORITY_HIGH`=0.
  - `valid`=1 and `multi`=1.
- All 256 input values are legal. There are no X outputs and no undefined codes.
- When `en`=0, `code`, `valid` and `multi` hold their previous values.

## Timing
- Latency: exactly 1 cycle. `data` sampled at rising edge N (with `en`=1) appears on the outputs after edge N, and the outputs are stable for all of cycle N+1.
- Throughput: one new encode per cycle. Back-to-back `en`=1 cycles update the outputs every cycle.
- Reset values: `code`=3'd0, `valid`=0, `multi`=0. These take effect at the first rising edge with `rst_n`=0.
- Reset priority: `rst_n`=0 overrides `en`. Reset mid-stream discards the sample on that edge.
- First capture after reset release: the first edge with `rst_n`=1 and `en`=1 loads new values.
- No combinational path from inputs to outputs.

## Structure
- Shared package `encoder_pkg` holds:
  - `DATA_W`=8 and `CODE_W`=3 (with `CODE_W` = $clog2(`DATA_W`));
  - the constant `NO_REQ_CODE`=3'd0.
- Sub-module `encoder_8x3_core`:
  - purely combinational;
  - parameterised on `PRIORITY_HIGH`;
  - outputs `w`, `any` and `many`.
- Top level `encoder_8x3`: instantiates the core, then the enable/reset output register stage.
- The popcount ≥ 2 detect is implemented as a pairwise OR/AND reduction. No full adder tree is required.

## Test plan
- Walking one: `data` = 8'h01 then shifted left each cycle through 8'h80 with `en`=1. Outputs give `code` 0,1,…,7 one cycle later, with `valid`=1 and `multi`=0 throughout.
- Zero input: `data`=8'h00, `en`=1. After the next edge `code`=0, `valid`=0, `multi`=0.
- Priority, `PRIORITY_HIGH`=1 instance:
  - 8'h81 gives `code`=7, `multi`=1;
  - 8'h0C gives `code`=3, `multi`=1.
- Priority, `PRIORITY_HIGH`=0 instance:
  - 8'h81 gives `code`=0, `multi`=1;
  - 8'h0C gives `code`=2, `multi`=1.
- Enable hold: load 8'h20 (`code`=5), then `en`=0 with `data`=8'h02 for 3 cycles. `code` stays 5 and `valid` stays 1. Raising `en` gives `code`=1 next cycle.
- Reset: with `en`=1 and `data`=8'hFF, drive `rst_n`=0 for one edge. Outputs become 0/0/0 on that edge. After `rst_n`=1, the next edge gives `code`=7, `valid`=1, `multi`=1.
